// File: rtl/queue_2x8_pkg.sv
// Shared constants, pointer/count types and the pointer-increment helper
// for the 2-entry x 8-bit register-file FIFO controller.
package queue_2x8_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;
  localparam int ADDR_W = 1;

  typedef logic [ADDR_W-1:0] q_ptr_t;
  typedef logic [1:0]        q_count_t;

  // Advance a pointer, wrapping from the last entry back to entry 0.
  function automatic q_ptr_t ptr_inc(input q_ptr_t p);
    if (p == q_ptr_t'(DEPTH - 1)) begin
      return '0;
    end
    return p + q_ptr_t'(1);
  endfunction

endpackage

// File: rtl/queue_2x8_ptr.sv
// Pointer bookkeeping for the FIFO: read/write pointers, the maybe_full
// disambiguation bit, flush handling, and the derived empty/full/count.
module queue_2x8_ptr
  import queue_2x8_pkg::*;
(
  input  logic     clock,
  input  logic     reset_n,
  input  logic     flush,
  input  logic     do_enq,
  input  logic     do_deq,
  output q_ptr_t   wr_ptr,
  output q_ptr_t   rd_ptr,
  output logic     empty,
  output logic     full,
  output q_count_t count
);

  logic maybe_full;
  logic ptr_match;

  // Pointer and maybe_full state; flush wins over any handshake this cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      maybe_full <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (do_enq) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_deq) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      // Equal pointers mean empty or full; the last unbalanced op tells which.
      if (do_enq != do_deq) begin
        maybe_full <= do_enq;
      end
    end
  end

  // Occupancy decode, purely from registered state.
  always_comb begin
    ptr_match = (wr_ptr == rd_ptr);
    empty     = ptr_match && !maybe_full;
    full      = ptr_match && maybe_full;
    count     = 2'd1;
    if (full) begin
      count = 2'd2;
    end else if (empty) begin
      count = 2'd0;
    end
  end

endmodule

// File: rtl/queue_2x8_ctrl.sv
// Ready/valid FIFO controller driving an external 2x8 register-file macro
// (synchronous W0 write port, combinational R0 read port). This level only
// maps handshakes onto the macro pins; state lives in queue_2x8_ptr.
module queue_2x8_ctrl
  import queue_2x8_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [DATA_W-1:0] enq_bits,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [DATA_W-1:0] deq_bits,
  output q_count_t          count,
  output q_ptr_t            W0_addr,
  output logic              W0_en,
  output logic [DATA_W-1:0] W0_data,
  output q_ptr_t            R0_addr,
  output logic              R0_en,
  input  logic [DATA_W-1:0] R0_data
);

  logic   empty;
  logic   full;
  logic   do_enq;
  logic   do_deq;
  q_ptr_t wr_ptr;
  q_ptr_t rd_ptr;

  // Readiness comes only from registered occupancy, so neither side sees a
  // combinational path from the other side's handshake.
  assign enq_ready = !full;
  assign deq_valid = !empty;
  assign do_enq    = enq_valid && enq_ready;
  assign do_deq    = deq_valid && deq_ready;

  // A flush discards this cycle's enqueue, so the macro must not be written.
  assign W0_en   = do_enq && !flush;
  assign W0_addr = wr_ptr;
  assign W0_data = enq_bits;
  assign R0_addr = rd_ptr;
  assign R0_en   = !empty;
  assign deq_bits = R0_data;

  queue_2x8_ptr u_ptr (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .do_enq  (do_enq),
    .do_deq  (do_deq),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

endmodule

// File: tb/tb_queue_2x8_ctrl.sv
// Scoreboard bench for queue_2x8_ctrl with a behavioural 2x8 macro model.
module tb_queue_2x8_ctrl;

  logic       clock;
  logic       reset_n;
  logic       flush;
  logic       enq_valid;
  logic       enq_ready;
  logic [7:0] enq_bits;
  logic       deq_valid;
  logic       deq_ready;
  logic [7:0] deq_bits;
  logic [1:0] count;
  logic       W0_addr;
  logic       W0_en;
  logic [7:0] W0_data;
  logic       R0_addr;
  logic       R0_en;
  logic [7:0] R0_data;

  logic [7:0] mem [2];
  logic [7:0] exp_q [$];
  int passed = 0;
  int total  = 0;

  queue_2x8_ctrl dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_bits  (enq_bits),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_bits  (deq_bits),
    .count     (count),
    .W0_addr   (W0_addr),
    .W0_en     (W0_en),
    .W0_data   (W0_data),
    .R0_addr   (R0_addr),
    .R0_en     (R0_en),
    .R0_data   (R0_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Macro model: synchronous write, combinational read.
  always @(posedge clock) begin
    if (W0_en) mem[W0_addr] <= W0_data;
  end
  assign R0_data = mem[R0_addr];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // Monitor: every completed dequeue outside a flush pops the scoreboard.
  always @(negedge clock) begin
    if (reset_n && deq_valid && deq_ready && !flush) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL deq_unexpected: got 0x%02h expected no output at %0t", deq_bits, $time);
      end else begin
        check("deq_data", deq_bits, exp_q.pop_front());
      end
    end
  end

  task automatic set_in(input logic ev, input logic [7:0] eb, input logic dr, input logic fl);
    enq_valid = ev;
    enq_bits  = eb;
    deq_ready = dr;
    flush     = fl;
  endtask

  task automatic to_neg();
    @(negedge clock);
  endtask

  task automatic to_next();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    mem[0] = 8'h00;
    mem[1] = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    // Reset values
    to_neg();
    check("rst_enq_ready", {7'b0, enq_ready}, 8'h01);
    check("rst_deq_valid", {7'b0, deq_valid}, 8'h00);
    check("rst_count", {6'b0, count}, 8'h00);
    check("rst_W0_en", {7'b0, W0_en}, 8'h00);
    check("rst_R0_en", {7'b0, R0_en}, 8'h00);
    to_next();
    reset_n = 1'b1;

    // Fill with 0xA5, 0x3C; third enqueue refused; drain
    set_in(1'b1, 8'hA5, 1'b0, 1'b0);
    to_neg();
    check("fill0_count", {6'b0, count}, 8'h00);
    check("fill0_W0_en", {7'b0, W0_en}, 8'h01);
    exp_q.push_back(8'hA5);
    to_next();
    set_in(1'b1, 8'h3C, 1'b0, 1'b0);
    to_neg();
    check("fill1_count", {6'b0, count}, 8'h01);
    check("fill1_deq_bits", deq_bits, 8'hA5);
    exp_q.push_back(8'h3C);
    to_next();
    set_in(1'b1, 8'hFF, 1'b0, 1'b0);
    to_neg();
    check("full_count", {6'b0, count}, 8'h02);
    check("full_enq_ready", {7'b0, enq_ready}, 8'h00);
    check("full_W0_en", {7'b0, W0_en}, 8'h00);
    to_next();
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    to_neg();
    check("drain0_count", {6'b0, count}, 8'h02);
    to_next();
    to_neg();
    check("drain1_count", {6'b0, count}, 8'h01);
    to_next();
    to_neg();
    check("drained_deq_valid", {7'b0, deq_valid}, 8'h00);
    to_next();

    // Mid-stream asynchronous reset
    set_in(1'b1, 8'h11, 1'b0, 1'b0);
    to_next();
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    check("pre_rst_count", {6'b0, count}, 8'h01);
    reset_n = 1'b0;
    #1;
    check("arst_count", {6'b0, count}, 8'h00);
    check("arst_deq_valid", {7'b0, deq_valid}, 8'h00);
    check("arst_enq_ready", {7'b0, enq_ready}, 8'h01);
    check("arst_W0_addr", {7'b0, W0_addr}, 8'h00);
    check("arst_R0_addr", {7'b0, R0_addr}, 8'h00);
    check("arst_R0_en", {7'b0, R0_en}, 8'h00);
    exp_q.delete();
    to_next();
    reset_n = 1'b1;
    to_neg();
    check("post_rst_count", {6'b0, count}, 8'h00);
    check("post_rst_deq_valid", {7'b0, deq_valid}, 8'h00);
    to_next();

    // Continuous stream 0x00..0x0F, both sides ready
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, 8'(i), 1'b1, 1'b0);
      to_neg();
      check("stream_count", {6'b0, count}, (i == 0) ? 8'h00 : 8'h01);
      check("stream_enq_ready", {7'b0, enq_ready}, 8'h01);
      exp_q.push_back(8'(i));
      to_next();
    end
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    to_neg();
    check("stream_tail_count", {6'b0, count}, 8'h01);
    to_next();
    to_neg();
    check("stream_end_count", {6'b0, count}, 8'h00);
    to_next();

    // Full with simultaneous enq and deq: dequeue only
    set_in(1'b1, 8'h21, 1'b0, 1'b0);
    exp_q.push_back(8'h21);
    to_next();
    set_in(1'b1, 8'h22, 1'b0, 1'b0);
    exp_q.push_back(8'h22);
    to_next();
    set_in(1'b1, 8'h23, 1'b1, 1'b0);
    to_neg();
    check("fullrw_enq_ready", {7'b0, enq_ready}, 8'h00);
    check("fullrw_W0_en", {7'b0, W0_en}, 8'h00);
    to_next();
    set_in(1'b1, 8'h23, 1'b0, 1'b0);
    to_neg();
    check("fullrw_next_count", {6'b0, count}, 8'h01);
    check("fullrw_next_W0_en", {7'b0, W0_en}, 8'h01);
    exp_q.push_back(8'h23);
    to_next();
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (2) to_next();
    to_neg();
    check("fullrw_empty_count", {6'b0, count}, 8'h00);
    to_next();

    // Empty with simultaneous enq and deq: no fall-through
    set_in(1'b1, 8'h77, 1'b1, 1'b0);
    to_neg();
    check("ft_deq_valid", {7'b0, deq_valid}, 8'h00);
    exp_q.push_back(8'h77);
    to_next();
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    to_neg();
    check("ft_next_deq_valid", {7'b0, deq_valid}, 8'h01);
    check("ft_next_deq_bits", deq_bits, 8'h77);
    to_next();

    // Flush with one entry and an enqueue offered: write suppressed
    set_in(1'b1, 8'h41, 1'b0, 1'b0);
    to_next();
    set_in(1'b1, 8'h42, 1'b0, 1'b1);
    to_neg();
    check("flush1_enq_ready", {7'b0, enq_ready}, 8'h01);
    check("flush1_W0_en", {7'b0, W0_en}, 8'h00);
    to_next();
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    to_neg();
    check("flush1_after_count", {6'b0, count}, 8'h00);
    to_next();

    // Flush at count=2 with enqueue offered
    set_in(1'b1, 8'h31, 1'b0, 1'b0);
    to_next();
    set_in(1'b1, 8'h32, 1'b0, 1'b0);
    to_next();
    set_in(1'b1, 8'h99, 1'b0, 1'b1);
    to_neg();
    check("flush2_count", {6'b0, count}, 8'h02);
    check("flush2_W0_en", {7'b0, W0_en}, 8'h00);
    to_next();
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    to_neg();
    check("flush2_after_count", {6'b0, count}, 8'h00);
    check("flush2_after_deq_valid", {7'b0, deq_valid}, 8'h00);
    to_next();
    set_in(1'b1, 8'h5A, 1'b0, 1'b0);
    exp_q.push_back(8'h5A);
    to_next();
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    to_next();
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    to_neg();
    check("final_count", {6'b0, count}, 8'h00);
    check("scoreboard_empty", 8'(exp_q.size()), 8'h00);
    to_next();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
